// File: rtl/fetch_queue_stage.sv
// fetch_queue_stage
// Instruction-fetch stage with a DEPTH-entry prefetch queue for a 5-stage
// MIPS pipeline. Instruction words are fetched in order from instruction
// memory. Each {pc, inst} pair is buffered and handed to ID under a
// valid/ready handshake. A CP0 redirect or an ID branch flushes the queue
// and reloads the fetch address.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   redirect_en/redirect_addr   CP0 forced jump (highest priority)
//   branch_en/branch_addr       ID-stage taken branch/jump target
//   inst_ren/inst_addr          instruction memory request
//   inst_ack/inst_data          instruction memory response (same cycle)
//   id_ready                    ID accepts the head entry
//   out_valid/out_inst/out_pc   head entry presented to ID
//   out_pc_next                 out_pc + 4
//   ret_addr                    oldest unissued address (CP0 EPC source)
//   count                       queue occupancy
//   misalign_err                one-cycle pulse after a misaligned target
module fetch_queue_stage #(
    parameter int               ADDR_W   = 32,
    parameter int               DATA_W   = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      redirect_en,
    input  logic [ADDR_W-1:0]         redirect_addr,
    input  logic                      branch_en,
    input  logic [ADDR_W-1:0]         branch_addr,
    output logic                      inst_ren,
    output logic [ADDR_W-1:0]         inst_addr,
    input  logic                      inst_ack,
    input  logic [DATA_W-1:0]         inst_data,
    input  logic                      id_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_inst,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [ADDR_W-1:0]         out_pc_next,
    output logic [ADDR_W-1:0]         ret_addr,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      misalign_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
    logic [CNT_W-1:0]  count_q,    count_d;
    logic              misalign_q, misalign_d;

    logic              full;
    logic              empty;
    logic              flush;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    assign flush  = redirect_en | branch_en;
    assign target = redirect_en ? redirect_addr : branch_addr;

    // A flush cycle never hands an entry to ID, and nothing leaves during reset.
    assign out_valid = ~rst & ~empty & ~flush;
    assign pop       = out_valid & id_ready;
    // A full queue may still accept a word when the head leaves in the same cycle.
    assign inst_ren  = ~rst & ~flush & (~full | pop);
    assign push      = inst_ren & inst_ack;

    assign inst_addr    = fetch_pc_q;
    assign out_pc       = pc_mem[rd_ptr_q];
    assign out_inst     = inst_mem[rd_ptr_q];
    assign out_pc_next  = out_pc + ADDR_W'(4);
    assign ret_addr     = empty ? fetch_pc_q : out_pc;
    assign count        = count_q;
    assign misalign_err = misalign_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        misalign_d = 1'b0;
        if (flush) begin
            fetch_pc_d = {target[ADDR_W-1:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            misalign_d = |target[1:0];
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(4);
                wr_ptr_d   = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    // Storage carries no reset; push is already gated by rst and flush.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= fetch_pc_q;
            inst_mem[wr_ptr_q] <= inst_data;
        end
    end

endmodule

// File: tb/tb_fetch_queue_stage.sv
module tb_fetch_queue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_addr = '0;
    logic        inst_ack = 1'b0;
    logic        id_ready = 1'b0;

    logic        d_ren   [2];
    logic [31:0] d_addr  [2];
    logic [31:0] d_data  [2];
    logic        d_valid [2];
    logic [31:0] d_inst  [2];
    logic [31:0] d_pc    [2];
    logic [31:0] d_pcn   [2];
    logic [31:0] d_ret   [2];
    logic [31:0] d_cnt   [2];
    logic        d_mis   [2];
    logic [2:0]  cnt0;
    logic [3:0]  cnt1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign d_data[0] = d_addr[0] ^ 32'hA5A5_0000;
    assign d_data[1] = d_addr[1] ^ 32'hA5A5_0000;
    assign d_cnt[0]  = {29'd0, cnt0};
    assign d_cnt[1]  = {28'd0, cnt1};

    fetch_queue_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .RESET_PC(32'h0)) u0 (
        .clk(clk), .rst(rst),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .inst_ren(d_ren[0]), .inst_addr(d_addr[0]),
        .inst_ack(inst_ack), .inst_data(d_data[0]),
        .id_ready(id_ready),
        .out_valid(d_valid[0]), .out_inst(d_inst[0]), .out_pc(d_pc[0]),
        .out_pc_next(d_pcn[0]), .ret_addr(d_ret[0]),
        .count(cnt0), .misalign_err(d_mis[0])
    );

    fetch_queue_stage #(.ADDR_W(32), .DATA_W(32), .DEPTH(8), .RESET_PC(32'h400)) u1 (
        .clk(clk), .rst(rst),
        .redirect_en(redirect_en), .redirect_addr(redirect_addr),
        .branch_en(branch_en), .branch_addr(branch_addr),
        .inst_ren(d_ren[1]), .inst_addr(d_addr[1]),
        .inst_ack(inst_ack), .inst_data(d_data[1]),
        .id_ready(id_ready),
        .out_valid(d_valid[1]), .out_inst(d_inst[1]), .out_pc(d_pc[1]),
        .out_pc_next(d_pcn[1]), .ret_addr(d_ret[1]),
        .count(cnt1), .misalign_err(d_mis[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue of {pc, inst} per instance plus the fetch address.
    logic [63:0] mq [2][$];
    logic [31:0] m_fpc [2];
    logic        m_mis [2];
    int          m_depth [2] = '{4, 8};
    logic [31:0] m_rpc   [2] = '{32'h0, 32'h400};
    bit          started = 0;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          n;
            bit          flush, ev, er;
            logic [31:0] tgt;
            n     = mq[k].size();
            flush = redirect_en || branch_en;
            tgt   = redirect_en ? redirect_addr : branch_addr;
            ev    = !rst && (n > 0) && !flush;
            er    = !rst && !flush && ((n < m_depth[k]) || (ev && id_ready));
            if (started) begin
                chk($sformatf("u%0d.out_valid", k), {31'd0, d_valid[k]}, {31'd0, ev});
                chk($sformatf("u%0d.inst_ren", k), {31'd0, d_ren[k]}, {31'd0, er});
                chk($sformatf("u%0d.inst_addr", k), d_addr[k], m_fpc[k]);
                chk($sformatf("u%0d.count", k), d_cnt[k], n);
                chk($sformatf("u%0d.misalign", k), {31'd0, d_mis[k]}, {31'd0, m_mis[k]});
                chk($sformatf("u%0d.ret_addr", k), d_ret[k], (n > 0) ? mq[k][0][63:32] : m_fpc[k]);
                if (ev) begin
                    chk($sformatf("u%0d.out_pc", k), d_pc[k], mq[k][0][63:32]);
                    chk($sformatf("u%0d.out_inst", k), d_inst[k], mq[k][0][31:0]);
                    chk($sformatf("u%0d.out_pc_next", k), d_pcn[k], mq[k][0][63:32] + 32'd4);
                end
            end
            // Advance to the state after the coming rising edge.
            if (rst) begin
                mq[k].delete();
                m_fpc[k] = m_rpc[k];
                m_mis[k] = 1'b0;
            end else if (flush) begin
                mq[k].delete();
                m_fpc[k] = tgt & 32'hFFFF_FFFC;
                m_mis[k] = (tgt[1:0] != 2'b00);
            end else begin
                m_mis[k] = 1'b0;
                if (ev && id_ready) void'(mq[k].pop_front());
                if (er && inst_ack) begin
                    mq[k].push_back({m_fpc[k], m_fpc[k] ^ 32'hA5A5_0000});
                    m_fpc[k] = m_fpc[k] + 32'd4;
                end
            end
        end
        started = 1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then streaming at one instruction per cycle.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; inst_ack = 1'b1; id_ready = 1'b1;
        @(negedge clk);
        chk("lit.c1_addr", d_addr[0], 32'h0);
        chk("lit.c1_valid", {31'd0, d_valid[0]}, 32'd0);
        chk("lit.c1_ren", {31'd0, d_ren[0]}, 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lit.c2_pc", d_pc[0], 32'h0);
        chk("lit.c2_inst", d_inst[0], 32'hA5A5_0000);
        chk("lit.c2_cnt", d_cnt[0], 32'd1);
        chk("lit.c2_pc_u1", d_pc[1], 32'h400);
        next_cycle();
        @(negedge clk);
        chk("lit.c3_pc", d_pc[0], 32'h4);
        chk("lit.c3_cnt", d_cnt[0], 32'd1);
        repeat (10) next_cycle();

        // Fill with ID stalled, then drain.
        rst = 1'b1; id_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("lit.full_cnt", d_cnt[0], 32'd4);
        chk("lit.full_ren", {31'd0, d_ren[0]}, 32'd0);
        chk("lit.full_addr", d_addr[0], 32'h10);
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            id_ready = 1'b1;
            @(negedge clk);
            chk($sformatf("lit.drain%0d_pc", i), d_pc[0], 32'(i * 4));
            chk($sformatf("lit.drain%0d_cnt", i), d_cnt[0], 32'd4);
        end
        repeat (12) next_cycle();

        // Flush of a queue holding 0x20..0x2C, then priority and misalignment.
        rst = 1'b1;
        next_cycle();
        rst = 1'b0; branch_en = 1'b1; branch_addr = 32'h20; id_ready = 1'b0;
        next_cycle();
        branch_en = 1'b0;
        repeat (4) next_cycle();
        branch_en = 1'b1; branch_addr = 32'h100; id_ready = 1'b1;
        @(negedge clk);
        chk("lit.pre_ret", d_ret[0], 32'h20);
        chk("lit.pre_cnt", d_cnt[0], 32'd4);
        chk("lit.fl_valid", {31'd0, d_valid[0]}, 32'd0);
        next_cycle();
        branch_en = 1'b0;
        @(negedge clk);
        chk("lit.post_cnt", d_cnt[0], 32'd0);
        chk("lit.post_addr", d_addr[0], 32'h100);
        next_cycle();
        @(negedge clk);
        chk("lit.br_pc", d_pc[0], 32'h100);
        next_cycle();
        branch_en = 1'b1; branch_addr = 32'h100;
        redirect_en = 1'b1; redirect_addr = 32'h180;
        next_cycle();
        branch_en = 1'b0; redirect_en = 1'b0;
        @(negedge clk);
        chk("lit.prio_addr", d_addr[0], 32'h180);
        next_cycle();
        @(negedge clk);
        chk("lit.prio_pc", d_pc[0], 32'h180);
        next_cycle();
        redirect_en = 1'b1; redirect_addr = 32'h206;
        next_cycle();
        redirect_en = 1'b0;
        @(negedge clk);
        chk("lit.mis_pulse", {31'd0, d_mis[0]}, 32'd1);
        chk("lit.mis_addr", d_addr[0], 32'h204);
        chk("lit.empty_ret", d_ret[0], 32'h204);
        next_cycle();
        @(negedge clk);
        chk("lit.mis_clear", {31'd0, d_mis[0]}, 32'd0);
        chk("lit.mis_pc", d_pc[0], 32'h204);

        // Reset with three queued entries and a flush in the same cycle.
        next_cycle();
        rst = 1'b1; id_ready = 1'b0;
        next_cycle();
        rst = 1'b0;
        repeat (3) next_cycle();
        rst = 1'b1; branch_en = 1'b1; branch_addr = 32'h33;
        @(negedge clk);
        chk("lit.rst_cnt_before", d_cnt[1], 32'd3);
        chk("lit.rst_valid", {31'd0, d_valid[1]}, 32'd0);
        chk("lit.rst_ren", {31'd0, d_ren[1]}, 32'd0);
        next_cycle();
        rst = 1'b0; branch_en = 1'b0; id_ready = 1'b1;
        @(negedge clk);
        chk("lit.rst_cnt", d_cnt[1], 32'd0);
        chk("lit.rst_addr", d_addr[1], 32'h400);
        chk("lit.rst_mis", {31'd0, d_mis[1]}, 32'd0);
        next_cycle();
        @(negedge clk);
        chk("lit.rst_pc", d_pc[1], 32'h400);

        // Randomised traffic, including wrap of the fetch address.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            inst_ack    = ($urandom_range(0, 3) != 0);
            id_ready    = ($urandom_range(0, 3) != 0);
            rst         = ($urandom_range(0, 99) == 0);
            branch_en   = ($urandom_range(0, 19) == 0);
            redirect_en = ($urandom_range(0, 29) == 0);
            branch_addr   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                                        : ($urandom & 32'h0000_0FFF);
            redirect_addr = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF4 | ($urandom & 32'h3))
                                                        : ($urandom & 32'h0000_0FFF);
        end
        next_cycle();
        rst = 1'b0; branch_en = 1'b0; redirect_en = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
